wino_tile_accum_engine: RTL
===========================

// Module: wino_tile_accum_engine
// PURPOSE
//  Parametrised successor to the Winograd F(2x2,3x3) multiply/output stage. Takes transformed data tiles U and
//  filter tiles V one input channel per beat, over a valid/ready link, and multiplies them element-wise.
//  Accumulates the products over a runtime channel count, then applies the A^T*M*A output transform.
//  Emits one saturated 2x2 output tile with backpressure. Sits between the data/filter transforms and the ofmap writer.
// PARAMETERS
//  TW        12  signed element width of U and V
//  ACC_W     32  signed accumulator width per element (>= 2*TW)
//  OUT_W     32  signed output element width (saturating)
//  MAX_CH    64  largest supported channel count
//  OUT_SHIFT 0   arithmetic right shift applied to Y before saturation (undoes filter-transform prescale)
// PORTS
//  clk         in   1             clock, all state on rising edge
//  rst         in   1             synchronous reset, active-high
//  cfg_num_ch  in   $clog2(MAX_CH+1)  channels per tile; sampled on first beat of a tile
//  in_valid    in   1             U/V beat valid
//  in_ready    out  1             engine accepts beat
//  in_u        in   16*TW         transformed data tile, element e=r*4+c at [e*TW +: TW]
//  in_v        in   16*TW         transformed filter tile, same packing
//  out_valid   out  1             output tile valid
//  out_ready   in   1             downstream accepts tile
//  out_y       out  4*OUT_W       output tile, element r*2+c at [(r*2+c)*OUT_W +: OUT_W]
//  out_sat     out  1             at least one element of out_y was clipped
// BEHAVIOUR
//  - Reset: state=ACCUM, ch_cnt=0, in_ready=1, out_valid=0, out_y=0, out_sat=0, accumulators=0.
//  - FSM ACCUM -> XFORM -> OUT -> ACCUM. in_ready=1 only in ACCUM. A beat is accepted when in_valid&in_ready.
//  - ACCUM: on accept with ch_cnt==0, latch n=max(cfg_num_ch,1) and set acc[e]=U[e]*V[e]; otherwise set acc[e]+=U[e]*V[e].
//    Products are signed TW x TW, sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W.
//    ch_cnt increments on every accepted beat. On the accept with ch_cnt==n-1, clear ch_cnt and go to XFORM.
//  - cfg_num_ch > MAX_CH is clamped to MAX_CH. cfg_num_ch changes mid-tile are ignored.
//  - XFORM (1 cycle): t = A^T*acc*A, with A^T = [1 1 1 0; 0 1 -1 -1]. Compute at ACC_W+4 bits, no overflow.
//    Then arithmetic >>> OUT_SHIFT, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    Register out_y and out_sat, then go to OUT.
//  - OUT: out_valid=1. out_y and out_sat are held stable until out_valid&out_ready. Then out_valid=0 next cycle, go to ACCUM.
//  - Latency: last beat accepted at edge k -> out_valid=1 after edge k+1. Min tile period n+2 cycles.
//  - No in/out overlap: a new tile's first beat is accepted no earlier than the cycle after the out handshake.
//  - rst mid-tile or mid-OUT: the partial tile is discarded and all outputs return to reset values next cycle.
//    No stale tile is emitted.
//  - in_valid asserted outside ACCUM is ignored; the producer holds the beat until in_ready.
// STRUCTURE
//  - wino_pkg: TILE_ELEMS=16, OUT_ELEMS=4, A^T coefficient table, state enum {ACCUM,XFORM,OUT}, sat() function.
//  - Sub-module wino_out_xform_core: combinational A^T*M*A + shift + saturation (16xACC_W -> 4xOUT_W, sat flag).
//    It is reusable by the non-accumulating path.
//  - Top: FSM, channel counter, 16 MAC lanes (generate loop), output register.
// TESTING
//  1. cfg_num_ch=1, U=all 1, V=all 1 -> Y={9,-3,-3,1} (r0c0,r0c1,r1c0,r1c1), out_sat=0, out_valid exactly 2 cycles after beat edge.
//  2. cfg_num_ch=4, 4 back-to-back beats U=all 1, V=all 2 -> acc=8 per element, Y={72,-24,-24,8}, in_ready low for XFORM+OUT.
//  3. Backpressure: test 2 with out_ready=0 for 5 cycles -> out_valid held, out_y stable, in_ready=0, beats not accepted; tile emitted once.
//  4. OUT_W=16, cfg_num_ch=1, U=V=all 2047 -> Y={32767,-32768,-32768,32767}, out_sat=1.
//  5. cfg_num_ch=4, accept 2 beats, pulse rst -> out_valid=0, in_ready=1; then a new 1-channel all-1 tile gives Y={9,-3,-3,1}.
//  6. cfg_num_ch=0 -> treated as 1: one beat yields a tile. OUT_SHIFT=2 with test 2 input -> Y={18,-6,-6,2}.

Source files
------------

// File: rtl/wino_pkg.sv
// Shared constants, FSM states and saturation helper for the Winograd F(2x2,3x3) output stage.
package wino_pkg;

  localparam int TILE_ELEMS = 16;
  localparam int OUT_ELEMS  = 4;

  // A^T for F(2x2,3x3); A is its transpose, so one table serves both sides of A^T*M*A.
  localparam int AT_COEF [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  typedef enum logic [1:0] {
    ACCUM,
    XFORM,
    OUT
  } state_e;

  // Clamp a wide signed value into the range of a w-bit signed number (w <= 64).
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/wino_out_xform_core.sv
// Combinational Winograd output transform: Y = A^T*M*A, arithmetic shift, saturation to OUT_W.
module wino_out_xform_core
  import wino_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic [TILE_ELEMS*ACC_W-1:0] m,
  output logic [OUT_ELEMS*OUT_W-1:0]  y,
  output logic                        any_clip
);

  // Nine +/-1 terms per output element never need more than four extra bits.
  localparam int XW = ACC_W + 4;

  logic [OUT_ELEMS-1:0] clip;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_ELEMS; gi++) begin : g_out
      localparam int RI = gi / 2;
      localparam int CI = gi % 2;

      logic signed [XW-1:0] sum;
      logic signed [XW-1:0] elem;
      logic signed [XW-1:0] shifted;
      logic signed [63:0]   wide;
      logic signed [63:0]   clipped;
      int                   coef;

      always_comb begin
        sum  = '0;
        elem = '0;
        coef = 0;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            coef = AT_COEF[RI][r] * AT_COEF[CI][c];
            elem = XW'($signed(m[(r*4+c)*ACC_W +: ACC_W]));
            if (coef > 0) sum = sum + elem;
            else if (coef < 0) sum = sum - elem;
          end
        end
      end

      assign shifted  = sum >>> OUT_SHIFT;
      assign wide     = 64'(shifted);
      assign clipped  = wino_pkg::sat(wide, OUT_W);
      assign clip[gi] = (clipped != wide);
      assign y[gi*OUT_W +: OUT_W] = clipped[OUT_W-1:0];
    end
  endgenerate

  assign any_clip = |clip;

endmodule

// File: rtl/wino_tile_accum_engine.sv
// Winograd multiply/accumulate stage: per-channel element-wise U*V accumulation, then output transform.
module wino_tile_accum_engine
  import wino_pkg::*;
#(
  parameter int TW        = 12,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 32,
  parameter int MAX_CH    = 64,
  parameter int OUT_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(MAX_CH+1)-1:0]  cfg_num_ch,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TILE_ELEMS*TW-1:0]     in_u,
  input  logic [TILE_ELEMS*TW-1:0]     in_v,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_ELEMS*OUT_W-1:0]   out_y,
  output logic                         out_sat
);

  localparam int CW = $clog2(MAX_CH + 1);

  state_e                       state_reg, state_next;
  logic [CW-1:0]                ch_cnt_reg;
  logic [CW-1:0]                n_reg;
  logic [CW-1:0]                n_eff;
  logic                         accept, first, last;
  logic [TILE_ELEMS*ACC_W-1:0]  acc_flat;
  logic [OUT_ELEMS*OUT_W-1:0]   y_calc;
  logic                         sat_calc;

  always_comb begin
    if (cfg_num_ch == '0) n_eff = CW'(1);
    else if (cfg_num_ch > CW'(MAX_CH)) n_eff = CW'(MAX_CH);
    else n_eff = cfg_num_ch;
  end

  // The channel count is taken live on the first beat and from n_reg afterwards.
  assign first     = (ch_cnt_reg == '0);
  assign last      = first ? (n_eff == CW'(1)) : (ch_cnt_reg == n_reg - CW'(1));
  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == OUT);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && last) state_next = XFORM;
      XFORM:   state_next = OUT;
      OUT:     if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ACCUM;
      ch_cnt_reg <= '0;
      n_reg      <= '0;
      out_y      <= '0;
      out_sat    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (first) n_reg <= n_eff;
        ch_cnt_reg <= last ? '0 : ch_cnt_reg + CW'(1);
      end
      if (state_reg == XFORM) begin
        out_y   <= y_calc;
        out_sat <= sat_calc;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TILE_ELEMS; gi++) begin : g_mac
      logic signed [TW-1:0]    u_e, v_e;
      logic signed [2*TW-1:0]  prod;
      logic signed [ACC_W-1:0] prod_ext;
      logic signed [ACC_W-1:0] acc_reg;

      assign u_e      = in_u[gi*TW +: TW];
      assign v_e      = in_v[gi*TW +: TW];
      assign prod     = u_e * v_e;
      assign prod_ext = ACC_W'(prod);

      always_ff @(posedge clk) begin
        if (rst) acc_reg <= '0;
        else if (accept) acc_reg <= first ? prod_ext : acc_reg + prod_ext;
      end

      assign acc_flat[gi*ACC_W +: ACC_W] = acc_reg;
    end
  endgenerate

  wino_out_xform_core #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_xform (
    .m       (acc_flat),
    .y       (y_calc),
    .any_clip(sat_calc)
  );

endmodule
